// File: rtl/buffer_b_ctrl.sv
// Instruction sequencer for the ten-slot B-operand buffer.
// Ports: instr_* (host instruction handshake), data_* (LOAD element
// handshake), buf_* (B buffer controls), send_active, slot_valid,
// done / err (per-instruction completion and rejection pulses).
module buffer_b_ctrl #(
    parameter int MMU_SIZE = 10,
    parameter int VAR_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [1:0]          instr_op,
    input  logic [4:0]          instr_buf,
    input  logic [7:0]          instr_dim_x,
    input  logic [7:0]          instr_dim_y,
    input  logic [VAR_SIZE-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [1:0]          buf_cmd,
    output logic [4:0]          buf_sel,
    output logic [7:0]          buf_dim_x,
    output logic [7:0]          buf_dim_y,
    output logic                buf_stop,
    output logic [VAR_SIZE-1:0] buf_A,
    output logic                send_active,
    output logic [MMU_SIZE-1:0] slot_valid,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_LOAD, S_SEND, S_CLEAR, S_GAP
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [4:0]          slot_q, slot_d;
    logic [7:0]          dx_q, dx_d, dy_q, dy_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [MMU_SIZE-1:0] sv_q, sv_d;
    logic [7:0]          shx_q [MMU_SIZE];
    logic [7:0]          shx_d [MMU_SIZE];
    logic [7:0]          shy_q [MMU_SIZE];
    logic [7:0]          shy_d [MMU_SIZE];
    logic                err_q, err_d;

    logic        in_range, dims_ok, sel_valid, bad;
    logic [7:0]  sel_dx, sel_dy;
    logic [15:0] prod;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        slot_d  = slot_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        sv_d    = sv_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        err_d   = 1'b0;

        instr_ready = 1'b0;
        data_ready  = 1'b0;
        buf_cmd     = 2'b00;
        buf_sel     = slot_q;
        buf_dim_x   = 8'd0;
        buf_dim_y   = 8'd0;
        buf_stop    = 1'b0;
        buf_A       = '0;
        send_active = 1'b0;
        done        = 1'b0;

        // Look up the addressed slot's shadow state.
        sel_valid = 1'b0;
        sel_dx    = 8'd0;
        sel_dy    = 8'd0;
        for (int i = 0; i < MMU_SIZE; i++) begin
            if (instr_buf == 5'(i)) begin
                sel_valid = sv_q[i];
                sel_dx    = shx_q[i];
                sel_dy    = shy_q[i];
            end
        end

        in_range = instr_buf < 5'(MMU_SIZE);
        dims_ok  = (instr_dim_x != 8'd0) && (instr_dim_x <= 8'(MMU_SIZE))
                && (instr_dim_y != 8'd0) && (instr_dim_y <= 8'(MMU_SIZE));
        bad = !in_range
           || ((instr_op == OP_LOAD) && !dims_ok)
           || ((instr_op == OP_SEND) && !sel_valid);
        prod = {8'd0, dx_q} * {8'd0, dy_q};

        unique case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && (instr_op != OP_NOP)) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = instr_op;
                        slot_d  = instr_buf;
                        state_d = S_ISSUE;
                        dx_d    = 8'd0;
                        dy_d    = 8'd0;
                        if (instr_op == OP_LOAD) begin
                            dx_d = instr_dim_x;
                            dy_d = instr_dim_y;
                        end else if (instr_op == OP_SEND) begin
                            dx_d = sel_dx;
                            dy_d = sel_dy;
                        end
                        // Shadow state is updated as the instruction
                        // is taken, so it is visible from ISSUE on.
                        for (int i = 0; i < MMU_SIZE; i++) begin
                            if (instr_buf == 5'(i)) begin
                                if (instr_op == OP_LOAD) begin
                                    shx_d[i] = instr_dim_x;
                                    shy_d[i] = instr_dim_y;
                                end else if (instr_op == OP_CLEAR) begin
                                    shx_d[i] = 8'd0;
                                    shy_d[i] = 8'd0;
                                    sv_d[i]  = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            S_ISSUE: begin
                buf_cmd   = op_q;
                buf_dim_x = dx_q;
                buf_dim_y = dy_q;
                cnt_d     = 16'd0;
                unique case (op_q)
                    OP_LOAD: state_d = S_LOAD;
                    OP_SEND: state_d = S_SEND;
                    default: state_d = S_CLEAR;
                endcase
            end
            S_LOAD: begin
                data_ready = 1'b1;
                buf_A      = data_in;
                buf_stop   = !data_valid;
                if (data_valid) begin
                    if (cnt_q == prod - 16'd1) begin
                        state_d = S_GAP;
                        for (int i = 0; i < MMU_SIZE; i++) begin
                            if (slot_q == 5'(i)) sv_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_SEND: begin
                send_active = 1'b1;
                if (cnt_q == {8'd0, dx_q} - 16'd1) state_d = S_GAP;
                else cnt_d = cnt_q + 16'd1;
            end
            S_CLEAR: begin
                if (cnt_q == 16'(MMU_SIZE - 1)) state_d = S_GAP;
                else cnt_d = cnt_q + 16'd1;
            end
            S_GAP: begin
                buf_sel = 5'd0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            slot_q  <= 5'd0;
            dx_q    <= 8'd0;
            dy_q    <= 8'd0;
            cnt_q   <= 16'd0;
            sv_q    <= '0;
            shx_q   <= '{default: 8'd0};
            shy_q   <= '{default: 8'd0};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            slot_q  <= slot_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            sv_q    <= sv_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            err_q   <= err_d;
        end
    end

    assign slot_valid = sv_q;
    assign err        = err_q;

endmodule

// File: tb/tb_buffer_b_ctrl.sv
// Self-checking bench for buffer_b_ctrl.
// Scenario tasks drive the sequencer; LOAD elements and SEND cycles are
// pushed to queues as they are driven and popped when the DUT produces them.
module tb_buffer_b_ctrl;

    localparam int MMU_SIZE = 10;
    localparam int VAR_SIZE = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                instr_valid;
    logic                instr_ready;
    logic [1:0]          instr_op;
    logic [4:0]          instr_buf;
    logic [7:0]          instr_dim_x;
    logic [7:0]          instr_dim_y;
    logic [VAR_SIZE-1:0] data_in;
    logic                data_valid;
    logic                data_ready;
    logic [1:0]          buf_cmd;
    logic [4:0]          buf_sel;
    logic [7:0]          buf_dim_x;
    logic [7:0]          buf_dim_y;
    logic                buf_stop;
    logic [VAR_SIZE-1:0] buf_A;
    logic                send_active;
    logic [MMU_SIZE-1:0] slot_valid;
    logic                done;
    logic                err;

    logic [VAR_SIZE-1:0] exp_q[$];
    int                  act_q[$];
    logic [MMU_SIZE-1:0] sv_model;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    buffer_b_ctrl #(.MMU_SIZE(MMU_SIZE), .VAR_SIZE(VAR_SIZE)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_buf(instr_buf),
        .instr_dim_x(instr_dim_x), .instr_dim_y(instr_dim_y),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .buf_cmd(buf_cmd), .buf_sel(buf_sel),
        .buf_dim_x(buf_dim_x), .buf_dim_y(buf_dim_y),
        .buf_stop(buf_stop), .buf_A(buf_A),
        .send_active(send_active), .slot_valid(slot_valid),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nextc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        instr_valid = 1'b0;
        instr_op    = 2'b00;
        instr_buf   = 5'd0;
        instr_dim_x = 8'd0;
        instr_dim_y = 8'd0;
        data_valid  = 1'b0;
        data_in     = '0;
    endtask

    task automatic offer(input logic [1:0] op, input logic [4:0] slot,
                         input logic [7:0] dx, input logic [7:0] dy);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_buf   = slot;
        instr_dim_x = dx;
        instr_dim_y = dy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        nextc();
        nextc();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        n_cmp++;
        if (slot_valid !== '0) begin
            n_bad++;
            $display("FAIL reset_slot_valid: got %h want 0", slot_valid);
        end
        n_cmp++;
        if ({buf_cmd, buf_stop, data_ready, send_active, done, err} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {buf_cmd, buf_stop, data_ready, send_active, done, err});
        end
        sv_model = '0;
    endtask

    task automatic test_load(input logic [4:0] slot, input logic [7:0] dx,
                             input logic [7:0] dy, input logic [31:0] stall,
                             input logic [7:0] base, input string nm);
        int n, drv, b, hs, ncmd;
        n = int'(dx) * int'(dy);
        drv = 0; b = 0; hs = 0; ncmd = 0;
        nextc();
        offer(2'b01, slot, dx, dy);
        data_valid = 1'b1;
        data_in    = 8'hEE;
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1 || data_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_accept: got ready=%b data_ready=%b want 1 0",
                     nm, instr_ready, data_ready);
        end
        if (buf_cmd == 2'b01) ncmd++;
        nextc();
        idle_in();
        @(negedge clk);
        if (buf_cmd == 2'b01) ncmd++;
        n_cmp++;
        if ({buf_cmd, buf_sel, buf_dim_x, buf_dim_y} !== {2'b01, slot, dx, dy}) begin
            n_bad++;
            $display("FAIL %s_issue: got cmd=%b sel=%0d dx=%0d dy=%0d want 01 %0d %0d %0d",
                     nm, buf_cmd, buf_sel, buf_dim_x, buf_dim_y, slot, dx, dy);
        end
        while (drv < n && b < 64) begin
            nextc();
            if (stall[b]) begin
                data_valid = 1'b0;
            end else begin
                data_valid = 1'b1;
                data_in    = base + 8'(drv);
                exp_q.push_back(base + 8'(drv));
                drv++;
            end
            @(negedge clk);
            if (buf_cmd == 2'b01) ncmd++;
            n_cmp++;
            if (buf_stop !== !data_valid || done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_beat%0d: got stop=%b done=%b want %b 0",
                         nm, b, buf_stop, done, !data_valid);
            end
            if (data_ready && data_valid) begin
                hs++;
                if (exp_q.size() > 0) begin
                    logic [VAR_SIZE-1:0] e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (buf_A !== e) begin
                        n_bad++;
                        $display("FAIL %s_elem: got %h want %h", nm, buf_A, e);
                    end
                end
            end
            b++;
        end
        nextc();
        idle_in();
        @(negedge clk);
        sv_model[slot] = 1'b1;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: got %b want 1 at cycle %0d", nm, done, 2 + b);
        end
        n_cmp++;
        if (slot_valid !== sv_model || buf_stop !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_gap: got sv=%h stop=%b want %h 0",
                     nm, slot_valid, buf_stop, sv_model);
        end
        n_cmp++;
        if (hs != n || ncmd != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_counts: got hs=%0d cmd=%0d left=%0d want %0d 1 0",
                     nm, hs, ncmd, exp_q.size(), n);
        end
        exp_q.delete();
        nextc();
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_return: got ready=%b done=%b want 1 0",
                     nm, instr_ready, done);
        end
    endtask

    task automatic test_send(input logic [4:0] slot, input int dx, input string nm);
        int cnt, done_c, errs;
        cnt = 0; done_c = -1; errs = 0;
        for (int k = 0; k < dx; k++) act_q.push_back(2 + k);
        nextc();
        offer(2'b10, slot, 8'd0, 8'd0);
        @(negedge clk);
        for (int c = 1; c <= dx + 4; c++) begin
            nextc();
            idle_in();
            @(negedge clk);
            if (err) errs++;
            if (done && done_c < 0) done_c = c;
            if (send_active) begin
                cnt++;
                if (act_q.size() > 0) begin
                    int e;
                    e = act_q.pop_front();
                    n_cmp++;
                    if (c != e) begin
                        n_bad++;
                        $display("FAIL %s_active_cycle: got %0d want %0d", nm, c, e);
                    end
                end
            end
        end
        n_cmp++;
        if (cnt != dx || act_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_active_len: got %0d want %0d", nm, cnt, dx);
        end
        n_cmp++;
        if (done_c != dx + 2 || errs != 0) begin
            n_bad++;
            $display("FAIL %s_done: got cycle %0d err %0d want %0d 0",
                     nm, done_c, errs, dx + 2);
        end
        act_q.delete();
    endtask

    task automatic test_reject(input logic [1:0] op, input logic [4:0] slot,
                               input logic [7:0] dx, input logic [7:0] dy,
                               input string nm);
        nextc();
        offer(op, slot, dx, dy);
        @(negedge clk);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready: got %b want 1", nm, instr_ready);
        end
        nextc();
        idle_in();
        @(negedge clk);
        n_cmp++;
        if ({err, instr_ready, buf_cmd} !== 4'b1100 || slot_valid !== sv_model) begin
            n_bad++;
            $display("FAIL %s_err: got err=%b rdy=%b cmd=%b sv=%h want 1 1 00 %h",
                     nm, err, instr_ready, buf_cmd, slot_valid, sv_model);
        end
        nextc();
        @(negedge clk);
        n_cmp++;
        if ({err, done, buf_cmd} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s_after: got err=%b done=%b cmd=%b want 0 0 00",
                     nm, err, done, buf_cmd);
        end
    endtask

    task automatic test_back_to_back();
        nextc();
        offer(2'b10, 5'd5, 8'd0, 8'd0);
        @(negedge clk);
        nextc();
        offer(2'b01, 5'd12, 8'd2, 8'd2);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first: got err=%b rdy=%b want 1 1", err, instr_ready);
        end
        nextc();
        offer(2'b00, 5'd3, 8'd0, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || instr_ready !== 1'b1 || buf_cmd !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_second: got err=%b rdy=%b cmd=%b want 1 1 00",
                     err, instr_ready, buf_cmd);
        end
        nextc();
        idle_in();
        @(negedge clk);
        n_cmp++;
        if ({err, done, instr_ready, buf_cmd} !== 5'b00100 || slot_valid !== sv_model) begin
            n_bad++;
            $display("FAIL b2b_nop: got err=%b done=%b rdy=%b cmd=%b sv=%h want 0 0 1 00 %h",
                     err, done, instr_ready, buf_cmd, slot_valid, sv_model);
        end
    endtask

    task automatic test_clear(input logic [4:0] slot);
        int done_c, cmds;
        done_c = -1; cmds = 0;
        nextc();
        offer(2'b11, slot, 8'd0, 8'd0);
        @(negedge clk);
        nextc();
        idle_in();
        @(negedge clk);
        sv_model[slot] = 1'b0;
        n_cmp++;
        if (buf_cmd !== 2'b11 || slot_valid !== sv_model) begin
            n_bad++;
            $display("FAIL clear_issue: got cmd=%b sv=%h want 11 %h",
                     buf_cmd, slot_valid, sv_model);
        end
        for (int c = 2; c <= 14; c++) begin
            nextc();
            @(negedge clk);
            if (done && done_c < 0) done_c = c;
            if (buf_cmd != 2'b00) cmds++;
        end
        n_cmp++;
        if (done_c != MMU_SIZE + 2 || cmds != 0) begin
            n_bad++;
            $display("FAIL clear_done: got cycle %0d cmds %0d want %0d 0",
                     done_c, cmds, MMU_SIZE + 2);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        dn = 0;
        nextc();
        offer(2'b01, 5'd5, 8'd3, 8'd3);
        @(negedge clk);
        nextc();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            nextc();
            data_valid = 1'b1;
            data_in    = 8'(k);
            if (k == 2) rst = 1'b1;
        end
        nextc();
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        sv_model = '0;
        n_cmp++;
        if ({instr_ready, done, buf_stop} !== 3'b100 || slot_valid !== '0) begin
            n_bad++;
            $display("FAIL midreset_state: got rdy=%b done=%b stop=%b sv=%h want 1 0 0 0",
                     instr_ready, done, buf_stop, slot_valid);
        end
        for (int c = 0; c < 4; c++) begin
            nextc();
            @(negedge clk);
            if (done) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_bad++;
            $display("FAIL midreset_nodone: got %0d done pulses want 0", dn);
        end
    endtask

    initial begin
        test_reset();
        test_load(5'd3, 8'd2, 8'd3, 32'h0, 8'd1, "load3");
        test_load(5'd0, 8'd3, 8'd3, 32'h12, 8'h10, "load0_stall");
        test_send(5'd3, 2, "send3");
        test_reject(2'b10, 5'd5, 8'd0, 8'd0, "rej_send5");
        test_reject(2'b01, 5'd12, 8'd2, 8'd2, "rej_slot12");
        test_reject(2'b01, 5'd1, 8'd11, 8'd2, "rej_dimx11");
        test_reject(2'b01, 5'd1, 8'd2, 8'd0, "rej_dimy0");
        test_back_to_back();
        test_load(5'd9, 8'd10, 8'd1, 32'h0, 8'h40, "load9_max");
        test_send(5'd9, 10, "send9");
        test_clear(5'd3);
        test_reject(2'b10, 5'd3, 8'd0, 8'd0, "rej_send_cleared");
        test_reset_mid();
        test_reject(2'b10, 5'd0, 8'd0, 8'd0, "rej_send_after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
